sm4_request_arbiter: RTL and testbench
======================================

# sm4_request_arbiter

Round-robin front-end that shares one `sm4_encryptor` core among `num_req_p` independent requesters. It accepts one request at a time, sequences it through the core's valid/ready and valid/yumi handshakes, and returns the result only to the requester that issued it. It also schedules cache-invalidation pulses so they never collide with an operation in flight. It sits between the system request fabric and the core.

## Interface
- `num_req_p`, default 4: number of requesters, 2..8.
- `group_size_p`, default from `sm4_encryptor_pkg` (128): data/key width.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset, asynchronous, active-high.
- `req_v_i`  in  num_req_p  per-requester request valid.
- `req_ready_o`  out  num_req_p  per-requester accept; at most one bit high.
- `req_content_i`  in  num_req_p×group_size_p  plaintext or ciphertext.
- `req_key_i`  in  num_req_p×group_size_p  key.
- `req_decode_i`  in  num_req_p  1 = decode.
- `resp_v_o`  out  num_req_p  result valid; only the owner's bit is high.
- `resp_data_o`  out  group_size_p  result, shared by all requesters.
- `resp_yumi_i`  in  num_req_p  per-requester result consume.
- `flush_i`  in  1  request a core cache invalidation; single-cycle pulse.
- `core_v_o` / `core_ready_i`: core input handshake.
- `core_content_o`, `core_key_o`  out  group_size_p each: core operands.
- `core_decode_o`  out  1: core mode select.
- `core_v_i`  in  1  core result valid.
- `core_data_i`  in  group_size_p  core result.
- `core_yumi_o`  out  1  core result consume.
- `core_invalid_cache_o`  out  1  single-cycle pulse to the core's cache invalidation.
- `busy_o`  out  1  state ≠ eIdle.
- `owner_o`  out  $clog2(num_req_p)  index of the current grant.

## Operation
- FSM states: eIdle, eIssue, eWait, eResp.
- **eIdle**
  - If `flush_pend_r` is set: drive `core_invalid_cache_o`=1 for one cycle, clear `flush_pend_r`, stay in eIdle, and grant nothing this cycle.
  - Otherwise, if any `req_v_i` bit is set: grant g, the first set bit at or after `rr_ptr_r` with wrap-around. Drive `req_ready_o[g]`=1 combinationally, latch content, key and mode into operand registers, set `owner_r`=g, and go to eIssue.
- **eIssue**: `core_v_o`=1 with the latched operands. When `core_ready_i`=1, go to eWait.
- **eWait**: `core_yumi_o` = `core_v_i`. When `core_v_i`=1, capture `core_data_i` into `resp_r` and go to eResp.
- **eResp**: `resp_v_o[owner_r]`=1 and `resp_data_o` = `resp_r`. When `resp_yumi_i[owner_r]`=1, set `rr_ptr_r` = (`owner_r`+1) mod `num_req_p` and go to eIdle.
  - `resp_yumi_i` from any non-owner is ignored.
- **Flush handling**
  - A `flush_i` pulse in any state sets `flush_pend_r`.
  - A flush that arrives while `flush_pend_r` is already set merges into the same pending flush.
  - A flush is serviced only in eIdle, and takes priority over new grants.
- **Request stability**: requesters must hold the request stable until they see `req_ready_o`. Dropping `req_v_i` before acceptance is legal; no grant is made for that request.

## Timing
- Reset values:
  - state eIdle; `rr_ptr_r`=0; `owner_r`=0; `flush_pend_r`=0; operand registers and `resp_r`=0.
  - All `_o` outputs are 0, except `resp_data_o`, which equals `resp_r` and is therefore 0.
- **Latency**: request accepted at cycle T → `core_v_o` high at T+1 → result presented on `resp_v_o` the cycle after the `core_v_i` handshake.
- **Arbiter overhead**: 3 cycles plus core latency. Peak throughput is one operation per (core latency + 3) cycles.
- **Outputs**: all registered except `req_ready_o`, `core_yumi_o` and `core_invalid_cache_o`, which are combinational from state and registers.
- **Reset mid-operation**: state returns to eIdle immediately; the in-flight operation and any pending flush are discarded. The core shares `reset_i`.
- **Wrap-around**: with `rr_ptr_r`=`num_req_p`-1 and bits 0 and `num_req_p`-1 both requesting, `num_req_p`-1 wins.

## Structure
- `sm4_encryptor_pkg` provides `group_size_p`.
- Add the arbiter state enum `arb_state_e` to `sm4_encryptor_pkg`.
- Sub-module `sm4_rr_picker`: combinational function of the request vector and `rr_ptr` that produces a one-hot grant, the grant index and an any-valid flag.
- A top-level wrapper instantiates `sm4_request_arbiter` in front of `sm4_encryptor`.

## Test plan
- **Single requester, known-answer**: requester 0 sends key = content = 0123456789abcdeffedcba9876543210, decode = 0 → `resp_v_o`=4'b0001 with `resp_data_o` = 681edf34d206965e86b3e94f536e4246. Repeat with decode = 1 on that ciphertext → the plaintext returns.
- **Round-robin order**: `req_v_i`=4'b1111 held continuously → grant order 0, 1, 2, 3, 0. `req_ready_o` is never multi-hot.
- **Wrap-around**: `rr_ptr_r`=3 with `req_v_i`=4'b1001 → grant 3, then 0.
- **Response back-pressure**: owner holds `resp_yumi_i` low for 20 cycles while others request → no new `core_v_o` and `resp_data_o` stays stable. Non-owner yumi has no effect.
- **Flush deferral**: `flush_i` pulsed during eWait → `core_invalid_cache_o` is one cycle, in the first eIdle cycle after the response, and that cycle makes no grant.
- **Reset mid-operation**: assert `reset_i` during eWait → all outputs are 0 asynchronously, and the next request after release is granted from `rr_ptr_r`=0.

Source files
------------

// File: rtl/sm4_encryptor_pkg.sv
// Shared parameters and types for the SM4 encryptor and its request front-end.
package sm4_encryptor_pkg;

    localparam int group_size_p = 128;

    typedef enum logic [1:0] {
        eIdle  = 2'd0,
        eIssue = 2'd1,
        eWait  = 2'd2,
        eResp  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sm4_rr_picker.sv
// Round-robin pick: first set request bit at or after ptr_i, wrapping around.
module sm4_rr_picker #(
    parameter  int num_req_p = 4,
    localparam int idx_w_lp  = $clog2(num_req_p)
) (
    input  logic [num_req_p-1:0] req_i,
    input  logic [idx_w_lp-1:0]  ptr_i,
    output logic [num_req_p-1:0] grant_o,
    output logic [idx_w_lp-1:0]  idx_o,
    output logic                 any_o
);

    int j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int i = 0; i < num_req_p; i++) begin
            j = (int'(ptr_i) + i) % num_req_p;
            if (!any_o && req_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = idx_w_lp'(j);
            end
        end
    end

endmodule

// File: rtl/sm4_request_arbiter.sv
// Round-robin front-end sharing one SM4 core among num_req_p requesters,
// with cache-invalidation pulses deferred until the core is idle.
module sm4_request_arbiter
    import sm4_encryptor_pkg::*;
#(
    parameter  int num_req_p    = 4,
    parameter  int group_size_p = sm4_encryptor_pkg::group_size_p,
    localparam int idx_w_lp     = $clog2(num_req_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              req_ready_o,
    input  logic [num_req_p*group_size_p-1:0] req_content_i,
    input  logic [num_req_p*group_size_p-1:0] req_key_i,
    input  logic [num_req_p-1:0]              req_decode_i,
    output logic [num_req_p-1:0]              resp_v_o,
    output logic [group_size_p-1:0]           resp_data_o,
    input  logic [num_req_p-1:0]              resp_yumi_i,
    input  logic                              flush_i,
    output logic                              core_v_o,
    input  logic                              core_ready_i,
    output logic [group_size_p-1:0]           core_content_o,
    output logic [group_size_p-1:0]           core_key_o,
    output logic                              core_decode_o,
    input  logic                              core_v_i,
    input  logic [group_size_p-1:0]           core_data_i,
    output logic                              core_yumi_o,
    output logic                              core_invalid_cache_o,
    output logic                              busy_o,
    output logic [idx_w_lp-1:0]               owner_o
);

    arb_state_e                state_q, state_d;
    logic [idx_w_lp-1:0]       rr_ptr_q, rr_ptr_d;
    logic [idx_w_lp-1:0]       owner_q, owner_d;
    logic                      flush_pend_q, flush_pend_d;
    logic [group_size_p-1:0]   content_q, content_d;
    logic [group_size_p-1:0]   key_q, key_d;
    logic                      decode_q, decode_d;
    logic [group_size_p-1:0]   resp_q, resp_d;

    logic [num_req_p-1:0]      pick_grant;
    logic [idx_w_lp-1:0]       pick_idx;
    logic                      pick_any;

    sm4_rr_picker #(.num_req_p(num_req_p)) u_picker (
        .req_i   (req_v_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d              = state_q;
        rr_ptr_d             = rr_ptr_q;
        owner_d              = owner_q;
        content_d            = content_q;
        key_d                = key_q;
        decode_d             = decode_q;
        resp_d               = resp_q;
        flush_pend_d         = flush_pend_q | flush_i;
        req_ready_o          = '0;
        core_yumi_o          = 1'b0;
        core_invalid_cache_o = 1'b0;

        unique case (state_q)
            eIdle: begin
                // A pending flush owns this cycle; the grant waits one cycle.
                if (flush_pend_q) begin
                    core_invalid_cache_o = 1'b1;
                    flush_pend_d         = flush_i;
                end else if (pick_any && !reset_i) begin
                    req_ready_o = pick_grant;
                    owner_d     = pick_idx;
                    state_d     = eIssue;
                    for (int i = 0; i < num_req_p; i++) begin
                        if (pick_grant[i]) begin
                            content_d = req_content_i[i*group_size_p +: group_size_p];
                            key_d     = req_key_i[i*group_size_p +: group_size_p];
                            decode_d  = req_decode_i[i];
                        end
                    end
                end
            end
            eIssue: begin
                if (core_ready_i) state_d = eWait;
            end
            eWait: begin
                core_yumi_o = core_v_i;
                if (core_v_i) begin
                    resp_d  = core_data_i;
                    state_d = eResp;
                end
            end
            eResp: begin
                if (resp_yumi_i[owner_q]) begin
                    rr_ptr_d = (owner_q == idx_w_lp'(num_req_p - 1)) ? '0 : owner_q + 1'b1;
                    state_d  = eIdle;
                end
            end
            default: state_d = eIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= eIdle;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            flush_pend_q <= 1'b0;
            content_q    <= '0;
            key_q        <= '0;
            decode_q     <= 1'b0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            flush_pend_q <= flush_pend_d;
            content_q    <= content_d;
            key_q        <= key_d;
            decode_q     <= decode_d;
            resp_q       <= resp_d;
        end
    end

    assign core_v_o       = (state_q == eIssue);
    assign core_content_o = core_v_o ? content_q : '0;
    assign core_key_o     = core_v_o ? key_q : '0;
    assign core_decode_o  = core_v_o & decode_q;
    assign resp_v_o       = (state_q == eResp) ? (num_req_p'(1) << owner_q) : '0;
    assign resp_data_o    = resp_q;
    assign busy_o         = (state_q != eIdle);
    assign owner_o        = owner_q;

endmodule

// File: tb/tb_sm4_request_arbiter.sv
// Randomized bench for sm4_request_arbiter with a behavioural core stand-in.
module tb_sm4_request_arbiter;

    localparam int N = 4;
    localparam int G = 128;
    localparam logic [G-1:0] KAT_PT = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [G-1:0] KAT_CT = 128'h681edf34d206965e86b3e94f536e4246;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [N-1:0]     req_v_i, req_ready_o, req_decode_i;
    logic [N*G-1:0]   req_content_i, req_key_i;
    logic [N-1:0]     resp_v_o, resp_yumi_i;
    logic [G-1:0]     resp_data_o;
    logic             flush_i;
    logic             core_v_o, core_ready_i = 1'b0, core_decode_o;
    logic [G-1:0]     core_content_o, core_key_o, core_data_i;
    logic             core_v_i, core_yumi_o, core_invalid_cache_o, busy_o;
    logic [1:0]       owner_o;

    always #5 clk = ~clk;

    sm4_request_arbiter #(.num_req_p(N), .group_size_p(G)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o),
        .req_content_i(req_content_i), .req_key_i(req_key_i), .req_decode_i(req_decode_i),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
        .flush_i(flush_i),
        .core_v_o(core_v_o), .core_ready_i(core_ready_i),
        .core_content_o(core_content_o), .core_key_o(core_key_o), .core_decode_o(core_decode_o),
        .core_v_i(core_v_i), .core_data_i(core_data_i), .core_yumi_o(core_yumi_o),
        .core_invalid_cache_o(core_invalid_cache_o),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [G-1:0] act, input logic [G-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Stand-in for the SM4 core: known-answer pair, otherwise a cheap keyed mix.
    function automatic logic [G-1:0] sm4_ref(input logic [G-1:0] c, input logic [G-1:0] k, input logic d);
        if (!d && c == KAT_PT && k == KAT_PT) return KAT_CT;
        if (d && c == KAT_CT && k == KAT_PT) return KAT_PT;
        return {c[63:0], c[127:64]} ^ k ^ {G{d}};
    endfunction

    logic         cm_busy;
    int           cm_cnt, cyc, hs_cyc;
    logic [G-1:0] cm_res;

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            cyc <= 0; hs_cyc <= 0; cm_busy <= 1'b0; cm_cnt <= 0;
            core_v_i <= 1'b0; core_data_i <= '0; cm_res <= '0;
        end else begin
            cyc <= cyc + 1;
            if (!cm_busy && core_v_o && core_ready_i) begin
                cm_busy <= 1'b1;
                cm_cnt  <= $urandom_range(1, 4);
                cm_res  <= sm4_ref(core_content_o, core_key_o, core_decode_o);
            end else if (cm_busy && !core_v_i) begin
                if (cm_cnt <= 1) begin
                    core_v_i    <= 1'b1;
                    core_data_i <= cm_res;
                end else cm_cnt <= cm_cnt - 1;
            end else if (core_v_i && core_yumi_o) begin
                core_v_i    <= 1'b0;
                cm_busy     <= 1'b0;
                hs_cyc      <= cyc;
                core_data_i <= {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    always @(negedge clk) core_ready_i = !cm_busy && ($urandom_range(0, 2) != 0);

    always @(negedge clk) begin
        #2;
        if (!reset_i) check("onehot", G'($onehot0(req_ready_o)), 1);
    end

    // Reference state: round-robin pointer and per-requester operands.
    int           m_ptr;
    logic [G-1:0] cont[N], key[N];
    logic         dec[N];

    function automatic int exp_grant(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    task automatic load_reqs(input bit fixed);
        for (int i = 0; i < N; i++) begin
            if (!fixed) begin
                cont[i] = {$urandom, $urandom, $urandom, $urandom};
                key[i]  = {$urandom, $urandom, $urandom, $urandom};
                dec[i]  = 1'($urandom_range(0, 1));
            end
            req_content_i[i*G +: G] = cont[i];
            req_key_i[i*G +: G]     = key[i];
            req_decode_i[i]         = dec[i];
        end
    endtask

    task automatic run_op(input logic [N-1:0] mask, input int hold, input bit do_flush,
                          input bit fixed, output int g, output logic [G-1:0] rd);
        int n;
        bit flushed;
        logic [G-1:0] exp_d;
        load_reqs(fixed);
        req_v_i = mask;
        g = exp_grant(mask, m_ptr);
        #1;
        n = 0;
        while (req_ready_o == '0 && n < 20) begin @(negedge clk); #1; n++; end
        check("grant_lat", n, 0);
        check("grant", req_ready_o, N'(1) << g);
        check("no_inv", core_invalid_cache_o, 0);
        @(negedge clk);
        req_v_i = '0;
        #1;
        check("core_v", core_v_o, 1);
        check("core_content", core_content_o, cont[g]);
        check("core_key", core_key_o, key[g]);
        check("core_decode", core_decode_o, dec[g]);
        check("owner", owner_o, g);
        check("busy", busy_o, 1);
        exp_d = sm4_ref(cont[g], key[g], dec[g]);
        n = 0;
        flushed = 0;
        while (resp_v_o == '0 && n < 50) begin
            if (do_flush && !flushed && !core_v_o) begin flush_i = 1'b1; flushed = 1; end
            req_v_i = N'($urandom);
            @(negedge clk);
            flush_i = 1'b0;
            #1;
            n++;
            if (resp_v_o == '0) check("busy_no_grant", req_ready_o, 0);
        end
        check("resp_v", resp_v_o, N'(1) << g);
        check("resp_data", resp_data_o, exp_d);
        check("resp_lat", cyc, hs_cyc + 1);
        rd = resp_data_o;
        for (int k = 0; k < hold; k++) begin
            resp_yumi_i = N'($urandom) & ~(N'(1) << g);
            req_v_i     = N'($urandom);
            @(negedge clk);
            #1;
            check("bp_resp_v", resp_v_o, N'(1) << g);
            check("bp_data", resp_data_o, exp_d);
            check("bp_core_v", core_v_o, 0);
            check("bp_ready", req_ready_o, 0);
        end
        resp_yumi_i = N'(1) << g;
        req_v_i     = '0;
        @(negedge clk);
        resp_yumi_i = '0;
        m_ptr = (g + 1) % N;
        #1;
        check("idle", busy_o, 0);
        check("resp_v_clr", resp_v_o, 0);
        if (do_flush) begin
            req_v_i = '1;
            #1;
            check("inv_pulse", core_invalid_cache_o, 1);
            check("inv_nogrant", req_ready_o, 0);
            @(negedge clk);
            req_v_i = '0;
            #1;
            check("inv_once", core_invalid_cache_o, 0);
        end else begin
            check("no_inv_idle", core_invalid_cache_o, 0);
        end
    endtask

    initial begin
        int g, n;
        int rr_exp[5] = '{0, 1, 2, 3, 0};
        logic [G-1:0] rd;
        reset_i = 1'b1; req_v_i = '1; req_content_i = '0; req_key_i = '0; req_decode_i = '0;
        resp_yumi_i = '0; flush_i = 1'b0; m_ptr = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_outs", G'(|{req_ready_o, resp_v_o, core_v_o, core_content_o, core_key_o,
                              core_decode_o, core_yumi_o, core_invalid_cache_o, busy_o, owner_o}), 0);
        check("rst_resp_data", resp_data_o, 0);
        req_v_i = '0;
        reset_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_op(4'b1111, 0, 0, 0, g, rd);
            check("rr_order", g, rr_exp[i]);
        end

        cont[0] = KAT_PT; key[0] = KAT_PT; dec[0] = 1'b0;
        run_op(4'b0001, 0, 0, 1, g, rd);
        check("kat_enc", rd, KAT_CT);
        cont[0] = KAT_CT; dec[0] = 1'b1;
        run_op(4'b0001, 0, 0, 1, g, rd);
        check("kat_dec", rd, KAT_PT);

        run_op(4'b0100, 0, 0, 0, g, rd);
        run_op(4'b1001, 0, 0, 0, g, rd);
        check("wrap_first", g, 3);
        run_op(4'b1001, 0, 0, 0, g, rd);
        check("wrap_second", g, 0);

        run_op(4'b0010, 20, 0, 0, g, rd);
        run_op(4'b1111, 2, 1, 0, g, rd);

        // Reset in eWait with a flush pending: both must be discarded.
        load_reqs(0);
        req_v_i = 4'b0100;
        @(negedge clk);
        req_v_i = '0;
        n = 0;
        #1;
        while (!(busy_o && !core_v_o) && n < 20) begin @(negedge clk); #1; n++; end
        check("reach_wait", n < 20, 1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        req_v_i = '1;
        reset_i = 1'b1;
        #1;
        check("midrst_outs", G'(|{req_ready_o, resp_v_o, core_v_o, core_content_o, core_key_o,
                                 core_decode_o, core_yumi_o, core_invalid_cache_o, busy_o, owner_o}), 0);
        check("midrst_resp_data", resp_data_o, 0);
        req_v_i = '0;
        @(negedge clk);
        reset_i = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        run_op(4'b1110, 0, 0, 0, g, rd);
        check("post_rst_grant", g, 1);

        for (int r = 0; r < 40; r++)
            run_op(N'($urandom_range(1, 15)), $urandom_range(0, 3), ($urandom_range(0, 4) == 0), 0, g, rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
